// File: rtl/hit_vector_scanner.sv
// -----------------------------------------------------------------------------
// hit_vector_scanner
//
// Multi-cycle scanner for a wide CAM hit vector. A request carries a WIDTH-bit
// hit vector and a 2-bit mode. The vector is examined CHUNK bits per clock,
// and one result is returned through a valid/ready handshake.
//
// Modes:
//   00  count ones      (always NCH scan cycles)
//   01  find first set  (LSB side, ascending chunk order, early exit on hit)
//   10  find last set   (MSB side, descending chunk order, early exit on hit)
//   11  count zeros     (always NCH scan cycles)
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accept, high only while idle
//   in_vec     hit vector, captured on accept
//   in_mode    scan mode, captured on accept
//   out_valid  result valid, held until out_ready
//   out_ready  result accept
//   out_count  count (count modes) or bit index (find modes)
//   out_found  count modes: count != 0; find modes: any bit set
// -----------------------------------------------------------------------------
module hit_vector_scanner #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_found
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int POS_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] MODE_ONES  = 2'b00;
  localparam logic [1:0] MODE_FIRST = 2'b01;
  localparam logic [1:0] MODE_LAST  = 2'b10;
  localparam logic [1:0] MODE_ZEROS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Number of ones in a chunk, already zero-extended to the result width.
  function automatic logic [CNT_W-1:0] chunk_popcount(input logic [CHUNK-1:0] c);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + CNT_W'(c[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest set bit; the caller guarantees c != 0.
  function automatic logic [CNT_W-1:0] lowest_set(input logic [CHUNK-1:0] c);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) r = CNT_W'(i);
    end
    return r;
  endfunction

  // Index of the highest set bit; the caller guarantees c != 0.
  function automatic logic [CNT_W-1:0] highest_set(input logic [CHUNK-1:0] c);
    logic [CNT_W-1:0] r;
    r = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) r = CNT_W'(i);
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q,   vec_d;
  logic [1:0]       mode_q,  mode_d;
  logic [POS_W-1:0] pos_q,   pos_d;
  logic [CNT_W-1:0] acc_q,   acc_d;
  logic             found_q, found_d;

  logic [POS_W-1:0] chunk_idx;
  logic [WIDTH-1:0] shifted;
  logic [CHUNK-1:0] chunk;
  logic [CNT_W-1:0] chunk_base;
  logic [CNT_W-1:0] pc;
  logic             last_pos;

  // Chunk selection: find-last walks the chunks from the top down, every
  // other mode walks them from the bottom up.
  always_comb begin
    chunk_idx = pos_q;
    if (mode_q == MODE_LAST) begin
      chunk_idx = POS_W'(NCH - 1) - pos_q;
    end
    shifted    = vec_q >> (int'(chunk_idx) * CHUNK);
    chunk      = shifted[CHUNK-1:0];
    chunk_base = CNT_W'(chunk_idx) * CNT_W'(CHUNK);
    pc         = chunk_popcount(chunk);
    last_pos   = (pos_q == POS_W'(NCH - 1));
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mode_d  = mode_q;
    pos_d   = pos_q;
    acc_d   = acc_q;
    found_d = found_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          vec_d   = in_vec;
          mode_d  = in_mode;
          pos_d   = '0;
          acc_d   = '0;
          found_d = 1'b0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        pos_d = pos_q + POS_W'(1);
        unique case (mode_q)
          MODE_ONES, MODE_ZEROS: begin
            if (mode_q == MODE_ONES) begin
              acc_d = acc_q + pc;
            end else begin
              acc_d = acc_q + (CNT_W'(CHUNK) - pc);
            end
            if (last_pos) begin
              found_d = (acc_d != '0);
              state_d = ST_DONE;
            end
          end
          default: begin
            // Find modes: stop at the first chunk with any bit set. With no
            // hit the accumulator stays at the zero loaded on accept.
            if (chunk != '0) begin
              acc_d   = chunk_base + ((mode_q == MODE_FIRST) ? lowest_set(chunk)
                                                             : highest_set(chunk));
              found_d = 1'b1;
              state_d = ST_DONE;
            end else if (last_pos) begin
              state_d = ST_DONE;
            end
          end
        endcase
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers; a reset drops any scan in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      acc_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      acc_q   <= acc_d;
      found_q <= found_d;
    end
  end

  // Captured request payload; only meaningful while a scan is active.
  always_ff @(posedge clk) begin
    vec_q  <= vec_d;
    mode_q <= mode_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_count = acc_q;
  assign out_found = found_q;

endmodule
